// File: rtl/lock_pkg.sv
// Shared encodings for the combination-lock sequencer: states, display modes, BCD limits.
package lock_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_ENTER   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROGRAM = 3'd4
  } state_t;

  localparam logic [2:0] MODE_DIGITS  = 3'd0;
  localparam logic [2:0] MODE_OPEN    = 3'd1;
  localparam logic [2:0] MODE_ERROR   = 3'd2;
  localparam logic [2:0] MODE_LOCKOUT = 3'd3;
  localparam logic [2:0] MODE_PROG    = 3'd4;

  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      ST_OPEN:    return MODE_OPEN;
      ST_FAIL:    return MODE_ERROR;
      ST_LOCKOUT: return MODE_LOCKOUT;
      ST_PROGRAM: return MODE_PROG;
      default:    return MODE_DIGITS;
    endcase
  endfunction

  // First digit lives in the most significant nibble of the packed code.
  function automatic logic [3:0] code_nib(input logic [31:0] code, input int ndig,
                                          input logic [2:0] idx);
    return 4'(code >> (BCD_W * (ndig - 1 - int'(idx))));
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: digit entry, fail counting, timed lockout, display mode.
// Define LOCK_PROG_EN to build the PROGRAM state that rewrites the code from OPEN.
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int                 NDIGITS        = 6,
  parameter logic [4*NDIGITS-1:0] CODE         = 24'h305464,
  parameter int                 MAX_FAILS      = 3,
  parameter int                 LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic       prog,
  output logic [2:0] disp_mode,
  output logic [3:0] disp_digit,
  output logic [2:0] digit_idx,
  output logic [1:0] fail_count,
  output logic       open,
  output logic       locked_out
);

  localparam int TW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;

  state_t      state, state_nx;
  logic [2:0]  idx_nx;
  logic [1:0]  fails_nx;
  logic [3:0]  ddig_nx;
  logic        mis, mis_nx, cur_mis;
  logic        tload, tdone;
  logic [31:0] code_ext;
  logic        last;

`ifdef LOCK_PROG_EN
  logic [4*NDIGITS-1:0] code_q, code_nx, stage_q, stage_nx;
  assign code_ext = 32'(code_q);
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign code_ext    = 32'(CODE);
`endif

  assign last    = (digit_idx == 3'(NDIGITS - 1));
  assign cur_mis = (digit != code_nib(code_ext, NDIGITS, digit_idx)) || (digit > BCD_MAX);

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tload),
    .load_val (TW'(LOCKOUT_CYCLES - 1)),
    .done     (tdone)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = digit_idx;
    fails_nx = fail_count;
    mis_nx   = mis;
    ddig_nx  = disp_digit;
    tload    = 1'b0;
`ifdef LOCK_PROG_EN
    code_nx  = code_q;
    stage_nx = stage_q;
`endif
    case (state)
      ST_ENTER: begin
        if (clear) begin
          idx_nx = '0;
          mis_nx = 1'b0;
        end else if (digit_valid) begin
          ddig_nx = digit;
          if (last) begin
            idx_nx = '0;
            mis_nx = 1'b0;
            if (!(mis || cur_mis)) begin
              state_nx = ST_OPEN;
              fails_nx = '0;
            end else if (({1'b0, fail_count} + 3'd1) == 3'(MAX_FAILS)) begin
              state_nx = ST_LOCKOUT;
              tload    = 1'b1;
              fails_nx = 2'(MAX_FAILS);
            end else begin
              state_nx = ST_FAIL;
              fails_nx = fail_count + 2'd1;
            end
          end else begin
            idx_nx = digit_idx + 3'd1;
            mis_nx = mis | cur_mis;
          end
        end
      end
      ST_OPEN: begin
`ifdef LOCK_PROG_EN
        if (prog) begin
          state_nx = ST_PROGRAM;
          idx_nx   = '0;
          stage_nx = code_q;
        end else
`endif
        if (clear) state_nx = ST_ENTER;
      end
      ST_FAIL: if (clear) state_nx = ST_ENTER;
      ST_LOCKOUT: begin
        if (tdone) begin
          state_nx = ST_ENTER;
          fails_nx = '0;
        end
      end
`ifdef LOCK_PROG_EN
      // Writes go to a staging copy so an aborted program keeps the old code.
      ST_PROGRAM: begin
        if (clear) begin
          state_nx = ST_ENTER;
          idx_nx   = '0;
        end else if (digit_valid && digit <= BCD_MAX) begin
          stage_nx[BCD_W*(NDIGITS-1-int'(digit_idx)) +: BCD_W] = digit;
          ddig_nx = digit;
          if (last) begin
            code_nx  = stage_nx;
            state_nx = ST_ENTER;
            idx_nx   = '0;
          end else begin
            idx_nx = digit_idx + 3'd1;
          end
        end
      end
`endif
      default: state_nx = ST_ENTER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ENTER;
      digit_idx  <= '0;
      fail_count <= '0;
      mis        <= 1'b0;
      disp_digit <= '0;
      disp_mode  <= MODE_DIGITS;
      open       <= 1'b0;
      locked_out <= 1'b0;
`ifdef LOCK_PROG_EN
      code_q     <= CODE;
      stage_q    <= CODE;
`endif
    end else begin
      state      <= state_nx;
      digit_idx  <= idx_nx;
      fail_count <= fails_nx;
      mis        <= mis_nx;
      disp_digit <= ddig_nx;
      disp_mode  <= mode_of(state_nx);
      open       <= (state_nx == ST_OPEN);
      locked_out <= (state_nx == ST_LOCKOUT);
`ifdef LOCK_PROG_EN
      code_q     <= code_nx;
      stage_q    <= stage_nx;
`endif
    end
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
module tb_lock_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic       clear = 1'b0;
  logic       prog = 1'b0;
  logic [2:0] disp_mode;
  logic [3:0] disp_digit;
  logic [2:0] digit_idx;
  logic [1:0] fail_count;
  logic       is_open;
  logic       locked_out;

  lock_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .prog        (prog),
    .disp_mode   (disp_mode),
    .disp_digit  (disp_digit),
    .digit_idx   (digit_idx),
    .fail_count  (fail_count),
    .open        (is_open),
    .locked_out  (locked_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] mode;
    logic [3:0] dd;
    logic [2:0] idx;
    logic [1:0] fc;
    logic       op;
    logic       lo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [13:0] act, req;
      e   = q.pop_front();
      act = {disp_mode, disp_digit, digit_idx, fail_count, is_open, locked_out};
      req = {e.mode, e.dd, e.idx, e.fc, e.op, e.lo};
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got mode=%0d dd=%h idx=%0d fc=%0d open=%b lo=%b, want mode=%0d dd=%h idx=%0d fc=%0d open=%b lo=%b",
                    e.name, disp_mode, disp_digit, digit_idx, fail_count, is_open, locked_out,
                    e.mode, e.dd, e.idx, e.fc, e.op, e.lo);
    end
  end

  task automatic tick(input logic dv, input logic [3:0] d, input logic clr, input logic prg);
    digit_valid = dv; digit = d; clear = clr; prog = prg;
    @(posedge clk); #1;
    digit_valid = 1'b0; clear = 1'b0; prog = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [2:0] m, input logic [3:0] dd,
                            input logic [2:0] ix, input logic [1:0] fc, input logic op,
                            input logic lo);
    q.push_back('{cyc, n, m, dd, ix, fc, op, lo});
  endtask

  task automatic enter6(input logic [23:0] code, input logic [2:0] mid_mode,
                        input logic [1:0] fc0, input string n, input logic [2:0] m,
                        input logic [1:0] fc, input logic op, input logic lo);
    logic [23:0] c;
    logic [3:0]  d;
    c = code;
    for (int i = 0; i < 6; i++) begin
      d = c[23-4*i -: 4];
      tick(1'b1, d, 1'b0, 1'b0);
      if (i < 5) expect_out({n, "_mid"}, mid_mode, d, 3'(i + 1), fc0, 1'b0, 1'b0);
      else       expect_out(n, m, d, 3'd0, fc, op, lo);
    end
  endtask

  initial begin
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    expect_out("reset", 3'd0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    expect_out("idle", 3'd0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0);

    enter6(24'h305464, 3'd0, 2'd0, "open", 3'd1, 2'd0, 1'b1, 1'b0);
    checks++;
    if (is_open === 1'b1) passes++;
    else $display("FAIL open_direct: got open=%b, want 1", is_open);
    tick(1'b1, 4'd7, 1'b0, 1'b0);
    expect_out("open_hold", 3'd1, 4'h4, 3'd0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("relock", 3'd0, 4'h4, 3'd0, 2'd0, 1'b0, 1'b0);

    enter6(24'h305465, 3'd0, 2'd0, "fail1", 3'd2, 2'd1, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    expect_out("fail_hold", 3'd2, 4'h5, 3'd0, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("fail_clr", 3'd0, 4'h5, 3'd0, 2'd1, 1'b0, 1'b0);

    enter6(24'h111111, 3'd0, 2'd1, "fail2", 3'd2, 2'd2, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("fail2_clr", 3'd0, 4'h1, 3'd0, 2'd2, 1'b0, 1'b0);

    enter6(24'h305465, 3'd0, 2'd2, "lock", 3'd3, 2'd3, 1'b0, 1'b1);
    checks++;
    if (locked_out === 1'b1) passes++;
    else $display("FAIL lock_direct: got locked_out=%b, want 1", locked_out);
    for (int k = 1; k < 16; k++) begin
      tick(1'(k % 2), 4'd3, (k % 3) == 0, 1'b0);
      expect_out("lockout", 3'd3, 4'h5, 3'd0, 2'd3, 1'b0, 1'b1);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    expect_out("unlock", 3'd0, 4'h5, 3'd0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (fail_count === 2'd0) passes++;
    else $display("FAIL unlock_fc: got fail_count=%0d, want 0", fail_count);
    checks++;
    if (locked_out === 1'b0) passes++;
    else $display("FAIL unlock_lo: got locked_out=%b, want 0", locked_out);

    tick(1'b1, 4'd3, 1'b0, 1'b0);
    expect_out("pri_a", 3'd0, 4'h3, 3'd1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    expect_out("pri_b", 3'd0, 4'h0, 3'd2, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd5, 1'b1, 1'b0);
    expect_out("clr_pri", 3'd0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (digit_idx === 3'd0) passes++;
    else $display("FAIL clr_pri_direct: got digit_idx=%0d, want 0", digit_idx);
    enter6(24'h305464, 3'd0, 2'd0, "open2", 3'd1, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("relock2", 3'd0, 4'h4, 3'd0, 2'd0, 1'b0, 1'b0);

    enter6(24'h30A464, 3'd0, 2'd0, "bad_bcd", 3'd2, 2'd1, 1'b0, 1'b0);
    checks++;
    if (is_open === 1'b0) passes++;
    else $display("FAIL bad_bcd_direct: got open=%b, want 0", is_open);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("bad_clr", 3'd0, 4'h4, 3'd0, 2'd1, 1'b0, 1'b0);

`ifdef LOCK_PROG_EN
    enter6(24'h305464, 3'd0, 2'd1, "open3", 3'd1, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b1);
    expect_out("prog", 3'd4, 4'h4, 3'd0, 2'd0, 1'b0, 1'b0);
    enter6(24'h123456, 3'd4, 2'd0, "prog_done", 3'd0, 2'd0, 1'b0, 1'b0);
    enter6(24'h305464, 3'd0, 2'd0, "old_code", 3'd2, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    expect_out("old_clr", 3'd0, 4'h4, 3'd0, 2'd1, 1'b0, 1'b0);
    enter6(24'h123456, 3'd0, 2'd1, "new_code", 3'd1, 2'd0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("reset2", 3'd0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    enter6(24'h305464, 3'd0, 2'd0, "restored", 3'd1, 2'd0, 1'b1, 1'b0);
`endif

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL %s: got no comparison, want one by cycle %0d", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lock_seq_ctrl.md
# lock_seq_ctrl

Sequencing controller for the DE1-SoC combination lock. Accepts one BCD digit per strobe and compares the running entry against a stored 6-digit code. It counts failed attempts, enforces a timed lockout after repeated failures, and tells the downstream HEX display decoder what to show. It sits between the switch/key debounce front end and the seven-segment decoder.

## Interface
Parameters:
- `NDIGITS`, default 6: digits per attempt.
- `CODE`, default 24'h305464: reset code, packed BCD with the first digit in the MSB nibble.
- `MAX_FAILS`, default 3: consecutive failed attempts that trigger a lockout.
- `LOCKOUT_CYCLES`, default 16: lockout duration in clocks.

Ports:
- `clk`, in, 1: rising-edge clock, the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `digit_valid`, in, 1: single-cycle digit strobe.
- `digit`, in, 4: BCD digit, sampled when `digit_valid`=1.
- `clear`, in, 1: relock / acknowledge; level, sampled each cycle.
- `prog`, in, 1: enter code programming; only used when `LOCK_PROG_EN` is defined.
- `disp_mode`, out, 3: display mode, using the package constants.
- `disp_digit`, out, 4: last accepted digit.
- `digit_idx`, out, 3: number of digits accepted in the current attempt.
- `fail_count`, out, 2: consecutive failures so far.
- `open`, out, 1: lock open.
- `locked_out`, out, 1: lockout active.

## Operation
States: ENTER, OPEN, FAIL, LOCKOUT, and PROGRAM (PROGRAM exists only with the macro).
- Reset values: state=ENTER; `digit_idx`=0; `fail_count`=0; mismatch flag=0; `disp_digit`=0; `disp_mode`=MODE_DIGITS; `open`=0; `locked_out`=0; code register=`CODE`.
- ENTER, on an accepted digit:
  - `disp_digit` takes the digit and `digit_idx` increments.
  - The mismatch flag is set if the digit ≠ code nibble[`digit_idx`], or if the digit > 9.
- ENTER, on the NDIGITS-th digit:
  - No mismatch: go to OPEN and set `fail_count` to 0.
  - Mismatch, and `fail_count`+1 = `MAX_FAILS`: go to LOCKOUT, load the timer with `LOCKOUT_CYCLES`-1, and set `fail_count` to `MAX_FAILS`.
  - Mismatch otherwise: go to FAIL and increment `fail_count`.
  - In every case, `digit_idx` and the mismatch flag are cleared.
- `clear` in ENTER: discards the partial entry (`digit_idx`=0, flag=0). `clear` has priority over a simultaneous `digit_valid`.
- OPEN: `clear` goes to ENTER. Digits are ignored.
- FAIL: `clear` goes to ENTER. Digits are ignored. `fail_count` is held.
- LOCKOUT:
  - `clear` and digits are ignored.
  - The timer decrements every cycle.
  - In the cycle the timer reads 0, the state goes to ENTER and `fail_count` is set to 0.
- `disp_mode` by state: ENTER → MODE_DIGITS, OPEN → MODE_OPEN, FAIL → MODE_ERROR, LOCKOUT → MODE_LOCKOUT, PROGRAM → MODE_PROG.
- `open` is 1 exactly in OPEN. `locked_out` is 1 exactly in LOCKOUT.
- A `reset` asserted at any time forces all reset values immediately, including the code register. This abandons any in-progress attempt, lockout or programming.

## Timing
- All outputs are registered.
- Response to the strobe edge: the state and outputs change at the same rising edge that samples `digit_valid`/`digit`, so they are visible in the following cycle.
- Result latency: `open`/`disp_mode` reflect the result one cycle after the cycle in which the final digit is strobed.
- Strobe rate: back-to-back `digit_valid` on every cycle is legal.
- LOCKOUT duration: exactly `LOCKOUT_CYCLES` cycles.

## Configuration
- `LOCK_PROG_EN` defined:
  - `prog`=1 in OPEN goes to PROGRAM, with `digit_idx`=0.
  - In PROGRAM, each digit ≤ 9 is written into code nibble[`digit_idx`]; digits > 9 are ignored.
  - After the NDIGITS-th write the state goes to ENTER and the new code is in force.
  - `clear` in PROGRAM aborts to ENTER and the code register keeps its old value.
  - `prog` has priority over a simultaneous `clear` in OPEN.
- `LOCK_PROG_EN` undefined: `prog` is ignored, the PROGRAM state is not built, and the code is the constant `CODE`.

## Structure
- Package `lock_pkg` holds:
  - the state encoding;
  - the MODE_DIGITS=0, MODE_OPEN=1, MODE_ERROR=2, MODE_LOCKOUT=3, MODE_PROG=4 constants;
  - the BCD digit width (4) and the max-BCD constant (9).
- One sub-module, `lock_timer`: a loadable down-counter with a `load`/`done` interface, used for LOCKOUT.

## Test plan
- Reset, then strobe 3,0,5,4,6,4 → `open`=1 and `disp_mode`=1 one cycle after the last strobe; `fail_count`=0.
- Strobe 3,0,5,4,6,5 → `disp_mode`=2 and `fail_count`=1; `clear` → ENTER with `digit_idx`=0.
- Three wrong attempts (each followed by `clear` after a failure) → third gives `locked_out`=1 for exactly 16 cycles; `clear`/digits during lockout are ignored; then ENTER with `fail_count`=0.
- Strobe 3,0 then `clear` and `digit_valid`=1 (digit 5) in the same cycle → `digit_idx`=0; a subsequent correct 6 digits opens the lock.
- Strobe digit 4'hA at any position → that attempt fails; the lock does not open even if all other digits are correct.
- With `LOCK_PROG_EN`: open, pulse `prog`, strobe 1,2,3,4,5,6 → ENTER; 3,0,5,4,6,4 now fails and 1,2,3,4,5,6 opens; `reset` restores code 305464.
